tank_ctrl: RTL and testbench

//  Writer side of the tank-state interface that the VGA renderer reads.
//  - Converts debounced joystick levels into tank grid position/direction and one shell.
//  - Outputs are frame-synchronous shadow registers; the renderer never sees mid-frame changes.
//  - Sits between Joystick/Debounce outputs and VGA i_tank0_* inputs, in the 25 MHz VGA domain.

---
 rtl/tank_pkg.sv | 29 ++
 rtl/tick_div.sv | 16 +
 rtl/tank_ctrl.sv | 108 ++++++++++
 tb/tb_tank_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// tank_pkg: shared direction/position types, shell FSM states and the grid step helper.
package tank_pkg;
   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_RIGHT = 2'd1, DIR_DOWN = 2'd2, DIR_LEFT = 2'd3} dir_t;
   typedef struct packed {
      logic [5:0] x;
      logic [5:0] y;
      dir_t       dir;
   } tank_pos_t;
   typedef struct packed {
      tank_pos_t pos;
      logic      blocked;
   } step_t;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FLY = 2'd1, ST_COOL = 2'd2} shell_st_t;
   localparam int GRID_W_DEF = 40;
   localparam int GRID_H_DEF = 30;
   // Bounds are tested before the inc/dec so a blocked step never wraps.
   function automatic step_t step_cell(tank_pos_t pos, dir_t dir, int w, int h);
      step_t r;
      r.pos     = pos;
      r.blocked = 1'b0;
      case (dir)
         DIR_UP:    if (pos.y == 6'd0) r.blocked = 1'b1; else r.pos.y = pos.y - 6'd1;
         DIR_DOWN:  if (int'(pos.y) >= h - 1) r.blocked = 1'b1; else r.pos.y = pos.y + 6'd1;
         DIR_LEFT:  if (pos.x == 6'd0) r.blocked = 1'b1; else r.pos.x = pos.x - 6'd1;
         DIR_RIGHT: if (int'(pos.x) >= w - 1) r.blocked = 1'b1; else r.pos.x = pos.x + 6'd1;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/tick_div.sv
// tick_div: free-running 0..DIV-1 counter with a one-cycle tick on the last count.
module tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic i_rst,
   output logic o_tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      o_tick = (cnt_q == W'(DIV - 1));
      cnt_d  = o_tick ? '0 : cnt_q + W'(1);
   end
   always_ff @(posedge clk) cnt_q <= i_rst ? '0 : cnt_d;
endmodule

// File: rtl/tank_ctrl.sv
// tank_ctrl: joystick-driven tank and single shell, committed to the renderer once per frame.
module tank_ctrl
   import tank_pkg::*;
#(
   parameter int   GRID_W     = GRID_W_DEF,
   parameter int   GRID_H     = GRID_H_DEF,
   parameter int   MOVE_DIV   = 2_500_000,
   parameter int   SHELL_DIV  = 625_000,
   parameter int   COOL_TICKS = 8,
   parameter int   INIT_X     = 2,
   parameter int   INIT_Y     = 2,
   parameter dir_t INIT_DIR   = DIR_UP
) (
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_left,
   input  logic       i_right,
   input  logic       i_fire,
   input  logic       i_frame_start,
   output logic [5:0] o_tank_x,
   output logic [5:0] o_tank_y,
   output logic [1:0] o_tank_dir,
   output logic       o_shell_valid,
   output logic [5:0] o_shell_x,
   output logic [5:0] o_shell_y
);
   localparam int CW = $clog2(COOL_TICKS + 1);
   localparam tank_pos_t INIT_POS = '{x: 6'(INIT_X), y: 6'(INIT_Y), dir: INIT_DIR};
   logic          move_tick, shell_tick, has_req;
   dir_t          req;
   step_t         tank_step, shell_step;
   tank_pos_t     tank_q, tank_d, shell_q, shell_d, o_tank_q, o_tank_d;
   logic          shell_valid_q, shell_valid_d, o_valid_q, o_valid_d, fire_q, fire_d;
   logic [5:0]    o_sx_q, o_sx_d, o_sy_q, o_sy_d;
   shell_st_t     st_q, st_d;
   logic [CW-1:0] cool_q, cool_d;
   tick_div #(.DIV(MOVE_DIV))  u_move  (.clk(clk), .i_rst(i_rst), .o_tick(move_tick));
   tick_div #(.DIV(SHELL_DIV)) u_shell (.clk(clk), .i_rst(i_rst), .o_tick(shell_tick));
   always_comb begin
      has_req       = i_up | i_down | i_left | i_right;
      req           = i_up ? DIR_UP : i_down ? DIR_DOWN : i_left ? DIR_LEFT : DIR_RIGHT;
      tank_step     = step_cell(tank_q, tank_q.dir, GRID_W, GRID_H);
      shell_step    = step_cell(shell_q, shell_q.dir, GRID_W, GRID_H);
      fire_d        = i_fire;
      tank_d        = tank_q;
      st_d          = st_q;
      shell_d       = shell_q;
      shell_valid_d = shell_valid_q;
      cool_d        = cool_q;
      if (move_tick && has_req && req != tank_q.dir) tank_d.dir = req;
      else if (move_tick && has_req && !tank_step.blocked) tank_d = tank_step.pos;
      case (st_q)
         ST_IDLE: if (i_fire && !fire_q) begin
            st_d          = ST_FLY;
            shell_d       = tank_q;
            shell_valid_d = 1'b1;
         end
         ST_FLY: if (shell_tick && shell_step.blocked) begin
            st_d          = ST_COOL;
            shell_valid_d = 1'b0;
            cool_d        = CW'(COOL_TICKS);
         end else if (shell_tick) shell_d = shell_step.pos;
         ST_COOL: if (shell_tick) begin
            cool_d = cool_q - CW'(1);
            st_d   = (cool_q <= CW'(1)) ? ST_IDLE : ST_COOL;
         end
         default: st_d = ST_IDLE;
      endcase
      // Shadow registers sample the pre-edge internal state only at frame start.
      o_tank_d  = i_frame_start ? tank_q : o_tank_q;
      o_valid_d = i_frame_start ? shell_valid_q : o_valid_q;
      o_sx_d    = i_frame_start ? (shell_valid_q ? shell_q.x : 6'd0) : o_sx_q;
      o_sy_d    = i_frame_start ? (shell_valid_q ? shell_q.y : 6'd0) : o_sy_q;
   end
   always_ff @(posedge clk) begin
      if (i_rst) begin
         tank_q        <= INIT_POS;
         shell_q       <= '0;
         shell_valid_q <= 1'b0;
         st_q          <= ST_IDLE;
         cool_q        <= '0;
         fire_q        <= 1'b0;
         o_tank_q      <= INIT_POS;
         o_valid_q     <= 1'b0;
         o_sx_q        <= '0;
         o_sy_q        <= '0;
      end else begin
         tank_q        <= tank_d;
         shell_q       <= shell_d;
         shell_valid_q <= shell_valid_d;
         st_q          <= st_d;
         cool_q        <= cool_d;
         fire_q        <= fire_d;
         o_tank_q      <= o_tank_d;
         o_valid_q     <= o_valid_d;
         o_sx_q        <= o_sx_d;
         o_sy_q        <= o_sy_d;
      end
   end
   assign o_tank_x      = o_tank_q.x;
   assign o_tank_y      = o_tank_q.y;
   assign o_tank_dir    = o_tank_q.dir;
   assign o_shell_valid = o_valid_q;
   assign o_shell_x     = o_sx_q;
   assign o_shell_y     = o_sy_q;
endmodule

// File: tb/tb_tank_ctrl.sv
// tb_tank_ctrl: directed steps; a behavioural model queues the expected commit at every frame start.
module tb_tank_ctrl;
   localparam int GW = 8, GH = 6, MD = 4, SD = 2, CT = 2, FP = 50;
   localparam logic [26:0] RST_VEC = {6'd2, 6'd2, 2'd0, 1'b0, 6'd0, 6'd0};
   logic clk = 1'b0, rst = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, fire = 1'b0, fs = 1'b0;
   logic [5:0] tx, ty, sx, sy;
   logic [1:0] td;
   logic sv;
   int n_chk = 0, n_fail = 0, fcnt = 0;
   int mx, my, md, mv, msx, msy, msd, mst, mcool, mfq, mmc, msc;
   logic [26:0] last = RST_VEC;
   logic [26:0] sb[$];
   always #5 clk = ~clk;
   tank_ctrl #(.GRID_W(GW), .GRID_H(GH), .MOVE_DIV(MD), .SHELL_DIV(SD), .COOL_TICKS(CT),
               .INIT_X(2), .INIT_Y(2), .INIT_DIR(tank_pkg::DIR_UP)) dut (
      .clk(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_left(left), .i_right(right),
      .i_fire(fire), .i_frame_start(fs), .o_tank_x(tx), .o_tank_y(ty), .o_tank_dir(td),
      .o_shell_valid(sv), .o_shell_x(sx), .o_shell_y(sy));
   task automatic check(string tag, logic [26:0] act, logic [26:0] exp);
      n_chk++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask
   function automatic bit blocked(int x, int y, int d);
      return (d == 0 && y == 0) || (d == 2 && y == GH - 1) || (d == 1 && x == GW - 1) || (d == 3 && x == 0);
   endfunction
   function automatic int nx(int x, int d);
      return d == 1 ? x + 1 : d == 3 ? x - 1 : x;
   endfunction
   function automatic int ny(int y, int d);
      return d == 2 ? y + 1 : d == 0 ? y - 1 : y;
   endfunction
   task automatic m_reset();
      mx = 2; my = 2; md = 0; mv = 0; msx = 0; msy = 0; msd = 0;
      mst = 0; mcool = 0; mfq = 0; mmc = 0; msc = 0;
   endtask
   task automatic cyc();
      int req;
      bit mt, stt;
      logic [26:0] e;
      fs = (fcnt == FP - 1);
      if (!rst) begin
         if (fs) sb.push_back({6'(mx), 6'(my), 2'(md), 1'(mv), 6'(mv ? msx : 0), 6'(mv ? msy : 0)});
         mt  = (mmc == MD - 1);
         stt = (msc == SD - 1);
         req = up ? 0 : down ? 2 : left ? 3 : right ? 1 : -1;
         if (mst == 0) begin
            if (fire && mfq == 0) begin mv = 1; msx = mx; msy = my; msd = md; mst = 1; end
         end else if (mst == 1) begin
            if (stt && blocked(msx, msy, msd)) begin mv = 0; mst = 2; mcool = CT; end
            else if (stt) begin msx = nx(msx, msd); msy = ny(msy, msd); end
         end else if (stt) begin
            mcool--;
            if (mcool == 0) mst = 0;
         end
         if (mt && req >= 0) begin
            if (req != md) md = req;
            else if (!blocked(mx, my, md)) begin mx = nx(mx, md); my = ny(my, md); end
         end
         mfq = int'(fire);
         mmc = mt ? 0 : mmc + 1;
         msc = stt ? 0 : msc + 1;
      end
      @(posedge clk);
      #1;
      fcnt = (fcnt + 1) % FP;
      if (rst) begin
         m_reset();
         last = RST_VEC;
         check("reset", {tx, ty, td, sv, sx, sy}, RST_VEC);
      end else if (fs) begin
         e = sb.pop_front();
         last = e;
         check("tank_x", 27'(tx), 27'(e[26:21]));
         check("tank_y", 27'(ty), 27'(e[20:15]));
         check("tank_dir", 27'(td), 27'(e[14:13]));
         check("shell_valid", 27'(sv), 27'(e[12]));
         check("shell_x", 27'(sx), 27'(e[11:6]));
         check("shell_y", 27'(sy), 27'(e[5:0]));
      end else check("hold", {tx, ty, td, sv, sx, sy}, last);
   endtask
   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask
   task automatic run_until(int k);
      while (FP - 1 - fcnt != k) cyc();
   endtask
   task automatic pulse_fire();
      fire = 1'b1;
      cyc();
      fire = 1'b0;
   endtask
   initial begin
      m_reset();
      rst = 1'b1; run(2); rst = 1'b0;
      run(200);
      check("idle_pos", {12'(0), tx, ty, td, sv}, {12'(0), 6'd2, 6'd2, 2'd0, 1'b0});
      up = 1'b1; run(16); up = 1'b0; run(2 * FP);
      check("clamp_top", {12'(0), tx, ty, td}, {12'(0), 6'd2, 6'd0, 2'd0});
      rst = 1'b1; run(1); rst = 1'b0;
      right = 1'b1; run(MD); right = 1'b0; run(2 * FP);
      check("turn_right", {12'(0), tx, ty, td}, {12'(0), 6'd2, 6'd2, 2'd1});
      right = 1'b1; run(MD); right = 1'b0; run(2 * FP);
      check("step_right", {12'(0), tx, ty, td}, {12'(0), 6'd3, 6'd2, 2'd1});
      up = 1'b1; right = 1'b1; run(MD); up = 1'b0; right = 1'b0; run(2 * FP);
      check("up_priority", {12'(0), tx, ty, td}, {12'(0), 6'd3, 6'd2, 2'd0});
      right = 1'b1; run(MD); right = 1'b0;
      run_until(5); pulse_fire(); run(40);
      run_until(13); pulse_fire();
      run_until(2); pulse_fire(); run(2);
      check("cool_ignore", 27'(sv), 27'(0));
      run_until(3); pulse_fire(); run(3);
      check("refire", {9'(0), sv, sx, sy}, {9'(0), 1'b1, 6'd4, 6'd2});
      run(40);
      run_until(5); fire = 1'b1; run(2 * FP);
      check("held_fire", 27'(sv), 27'(0));
      fire = 1'b0; run(20);
      up = 1'b1; run(MD); up = 1'b0;
      run_until(3); pulse_fire(); run(3);
      check("shell_up", {9'(0), sv, sx, sy}, {9'(0), 1'b1, 6'd3, 6'd1});
      run(30);
      down = 1'b1; run(40); down = 1'b0;
      left = 1'b1; run(40); left = 1'b0; run(2 * FP);
      check("clamp_corner", {12'(0), tx, ty, td}, {12'(0), 6'd0, 6'd5, 2'd3});
      run_until(3); pulse_fire(); run(3);
      check("border_shell", 27'(sv), 27'(0));
      run(30);
      run_until(10); pulse_fire(); run(3);
      rst = 1'b1; cyc(); rst = 1'b0;
      run(2 * FP);
      check("post_reset", {12'(0), tx, ty, td, sv}, {12'(0), 6'd2, 6'd2, 2'd0, 1'b0});
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
